led_fade_pwm: RTL

//   Output stage after the led pattern generator. Takes its N-bit on/off pattern
//   and drives each LED pin with PWM.

---
 rtl/led_fade_pwm.sv | 59 +++++
 1 files changed

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: turns an on/off LED pattern into PWM drive with linear fade ramps per channel
module led_fade_pwm #(
  parameter int N        = 6,
  parameter int PWM_W    = 4,
  parameter int STEP_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] led_in,
  output logic [N-1:0] led_out,
  output logic         period_start,
  output logic         busy
);
  localparam logic [PWM_W-1:0] MAXD  = '1;
  localparam int               SW    = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0]    SLAST = SW'(STEP_DIV - 1);
  typedef enum logic [1:0] {OFF, RISE, ON, FALL} state_t;
  logic [N-1:0]     led_q;
  logic [PWM_W-1:0] pwm_cnt;
  logic [SW-1:0]    step_cnt;
  logic [PWM_W-1:0] duty     [N];
  logic [PWM_W-1:0] duty_nxt [N];
  logic [N-1:0]     lit;
  logic [N-1:0]     miss;
  logic             pwm_last;
  logic             step_tick;
  assign pwm_last  = pwm_cnt == MAXD - 1'b1;
  assign step_tick = en && pwm_last && step_cnt == SLAST;
  assign busy      = |miss;
  // channel state is derived from duty and target, so a reversal mid-fade just flips direction
  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t st;
    assign st = duty[i] == '0   ? (led_q[i] ? RISE : OFF) :
                duty[i] == MAXD ? (led_q[i] ? ON : FALL) :
                                  (led_q[i] ? RISE : FALL);
    assign duty_nxt[i] = !step_tick  ? duty[i] :
                         st == RISE ? duty[i] + 1'b1 :
                         st == FALL ? duty[i] - 1'b1 : duty[i];
    assign lit[i]  = pwm_cnt < duty[i];
    assign miss[i] = duty[i] != (led_q[i] ? MAXD : '0);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      led_q        <= '0;
      pwm_cnt      <= '0;
      step_cnt     <= '0;
      led_out      <= '0;
      period_start <= 1'b0;
      for (int k = 0; k < N; k++) duty[k] <= '0;
    end else begin
      led_q        <= led_in;
      pwm_cnt      <= !en || pwm_last ? '0 : pwm_cnt + 1'b1;
      step_cnt     <= !en ? '0 : !pwm_last ? step_cnt : step_cnt == SLAST ? '0 : step_cnt + 1'b1;
      led_out      <= en ? lit : '0;
      period_start <= en && pwm_cnt == '0;
      for (int k = 0; k < N; k++) duty[k] <= duty_nxt[k];
    end
endmodule
